// File: rtl/window_request_sequencer_if.sv
// Request / completion handshake bundle for window_request_sequencer.
//   req_valid, req_tag  : request offered by the client
//   req_ready           : sequencer FIFO has room
//   cmp_valid, cmp_tag  : completion offered by the sequencer
//   cmp_timeout         : completion came from the watchdog, not strobe
//   cmp_ready           : client accepts the completion
// master = client side, slave = sequencer side.
interface window_request_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [TAG_W-1:0] req_tag;
  logic             cmp_valid;
  logic             cmp_ready;
  logic [TAG_W-1:0] cmp_tag;
  logic             cmp_timeout;

  modport master (
    output req_valid, req_tag, cmp_ready,
    input  req_ready, cmp_valid, cmp_tag, cmp_timeout
  );

  modport slave (
    input  req_valid, req_tag, cmp_ready,
    output req_ready, cmp_valid, cmp_tag, cmp_timeout
  );
endinterface

// File: rtl/window_request_sequencer.sv
// Issue stage in front of timing_window_gen. Queues tagged window requests
// in a DEPTH-entry FIFO and issues them one at a time as a one-cycle start
// pulse, then waits for the generator's strobe (or the watchdog) and hands
// the tag back on the completion port. Only one window is ever in flight.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/completion handshakes (slave side)
//   start      : one-cycle pulse to the generator
//   strobe     : window strobe returned by the generator
//   level      : FIFO occupancy
//   busy       : FSM not idle or FIFO not empty
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued request
// ISSUE | start pulse, head tag latched, FIFO pops, timer cleared
// WAIT  | window in flight, waiting for strobe or watchdog
// CMPL  | completion offered, held until cmp_ready
module window_request_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  window_request_sequencer_if.slave    bus,
  output logic                         start,
  input  logic                         strobe,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int TMR_W = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CMPL} state_t;

  state_t           state;
  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TMR_W-1:0] timer;
  logic [TAG_W-1:0] cur_tag;
  logic             cmp_valid_q;
  logic             cmp_timeout_q;
  logic             push;
  logic             pop;

  assign bus.req_ready   = (level != LVL_W'(DEPTH));
  assign push            = bus.req_valid && bus.req_ready;
  assign pop             = (state == ISSUE);
  assign bus.cmp_valid   = cmp_valid_q;
  assign bus.cmp_tag     = cur_tag;
  assign bus.cmp_timeout = cmp_timeout_q;
  assign busy            = (state != IDLE) || (level != '0);

  // Storage is not reset: entries are only ever read behind a valid level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.req_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // start is registered: it is raised on the transition into ISSUE so that
  // it is high for exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      start         <= 1'b0;
      timer         <= '0;
      cur_tag       <= '0;
      cmp_valid_q   <= 1'b0;
      cmp_timeout_q <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (level != '0) begin
            state <= ISSUE;
            start <= 1'b1;
          end
        end
        ISSUE: begin
          cur_tag <= mem[rd_ptr];
          timer   <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // strobe wins over a watchdog expiry in the same cycle
          if (strobe) begin
            state         <= CMPL;
            cmp_valid_q   <= 1'b1;
            cmp_timeout_q <= 1'b0;
          end else if (timer == TMR_W'(TIMEOUT)) begin
            state         <= CMPL;
            cmp_valid_q   <= 1'b1;
            cmp_timeout_q <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CMPL: begin
          if (bus.cmp_ready) begin
            cmp_valid_q   <= 1'b0;
            cmp_timeout_q <= 1'b0;
            if (level != '0) begin
              state <= ISSUE;
              start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_request_sequencer.sv
// Bench for window_request_sequencer: directed timing scenarios plus a
// randomized phase, all checked against a transaction-level model (tag queue
// plus an in-flight record resolved by strobe/watchdog arithmetic).
module tb_window_request_sequencer;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 7;
  localparam int LVL_W   = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start;
  logic             strobe = 1'b0;
  logic             busy;
  logic [LVL_W-1:0] level;

  window_request_sequencer_if #(.TAG_W(TAG_W)) bus ();

  window_request_sequencer #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .start(start),
    .strobe(strobe), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               c;
    logic [TAG_W-1:0] tag;
    logic             to;
  } cmp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model
  logic [TAG_W-1:0] mq[$];
  bit               inflight, res, res_to, exp_start;
  logic [TAG_W-1:0] cur;
  int               issue_c, res_c;

  // generator model and stimulus knobs
  bit gen_en, rnd_strobe;
  int gen_lat, last_start, force_strobe;

  // DUT-observed event logs for directed timing checks
  int   start_log[$];
  int   push_log[$];
  cmp_t cmp_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    start_log.delete();
    push_log.delete();
    cmp_log.delete();
  endtask

  task automatic model_reset();
    mq.delete();
    inflight     = 1'b0;
    res          = 1'b0;
    res_to       = 1'b0;
    exp_start    = 1'b0;
    last_start   = -1000;
    force_strobe = -1;
    clear_logs();
  endtask

  // Evaluates the current cycle: compares DUT outputs with the model and
  // advances the model as of the coming clock edge.
  task automatic monitor();
    int   lvl;
    bit   hs, exp_cv;
    cmp_t e;
    lvl = mq.size();
    check("level", 32'(level), 32'(lvl));
    check("req_ready", 32'(bus.req_ready), 32'(lvl != DEPTH));
    check("start", 32'(start), 32'(exp_start));
    if (start === 1'b1) begin
      start_log.push_back(cyc);
      last_start = cyc;
    end
    if (exp_start) begin
      inflight = 1'b1;
      res      = 1'b0;
      cur      = mq.pop_front();
      issue_c  = cyc;
    end
    check("busy", 32'(busy), 32'(inflight || lvl != 0));
    // the window waits TIMEOUT+1 cycles after the issue cycle
    if (inflight && !res && cyc > issue_c) begin
      if (strobe === 1'b1) begin
        res = 1'b1; res_to = 1'b0; res_c = cyc;
      end else if (cyc == issue_c + 1 + TIMEOUT) begin
        res = 1'b1; res_to = 1'b1; res_c = cyc;
      end
    end
    exp_cv = inflight && res && cyc > res_c;
    check("cmp_valid", 32'(bus.cmp_valid), 32'(exp_cv));
    if (exp_cv) begin
      check("cmp_tag", 32'(bus.cmp_tag), 32'(cur));
      check("cmp_timeout", 32'(bus.cmp_timeout), 32'(res_to));
    end
    if (bus.cmp_valid === 1'b1 && bus.cmp_ready) begin
      e.c = cyc; e.tag = bus.cmp_tag; e.to = bus.cmp_timeout;
      cmp_log.push_back(e);
    end
    if (bus.req_valid && bus.req_ready === 1'b1) push_log.push_back(cyc);
    hs        = exp_cv && bus.cmp_ready;
    exp_start = (!inflight || hs) && lvl > 0;
    if (hs) inflight = 1'b0;
    if (bus.req_valid && lvl != DEPTH) mq.push_back(bus.req_tag);
  endtask

  task automatic step();
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    strobe = (gen_en && cyc == last_start + gen_lat + 1) || (cyc == force_strobe) ||
             (rnd_strobe && $urandom_range(15) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int t0, n;
    bit got;

    bus.req_valid = 1'b0;
    bus.req_tag   = '0;
    bus.cmp_ready = 1'b1;
    gen_en = 1'b0; rnd_strobe = 1'b0; gen_lat = 3;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // single request, L=3
    clear_logs(); gen_en = 1'b1; gen_lat = 3;
    t0 = cyc; bus.req_valid = 1'b1; bus.req_tag = 4'h5; step();
    bus.req_valid = 1'b0;
    repeat (10) step();
    check("t1_start_n", 32'(start_log.size()), 32'd1);
    if (start_log.size() > 0) check("t1_start_cyc", 32'(start_log[0] - t0), 32'd2);
    check("t1_cmp_n", 32'(cmp_log.size()), 32'd1);
    if (cmp_log.size() > 0) begin
      check("t1_cmp_cyc", 32'(cmp_log[0].c - t0), 32'd7);
      check("t1_cmp_tag", 32'(cmp_log[0].tag), 32'h5);
      check("t1_cmp_to", 32'(cmp_log[0].to), 32'd0);
    end
    check("t1_busy", 32'(busy), 32'd0);

    // back-to-back, tags 1,2,3
    clear_logs(); t0 = cyc;
    for (int i = 1; i <= 3; i++) begin
      bus.req_valid = 1'b1; bus.req_tag = TAG_W'(i); step();
    end
    bus.req_valid = 1'b0;
    repeat (22) step();
    check("t2_start_n", 32'(start_log.size()), 32'd3);
    check("t2_cmp_n", 32'(cmp_log.size()), 32'd3);
    for (int k = 0; k < 3 && k < start_log.size(); k++)
      check("t2_start_cyc", 32'(start_log[k] - t0), 32'(2 + 6 * k));
    for (int k = 0; k < 3 && k < cmp_log.size(); k++) begin
      check("t2_cmp_tag", 32'(cmp_log[k].tag), 32'(k + 1));
      check("t2_cmp_to", 32'(cmp_log[k].to), 32'd0);
    end

    // full FIFO, strobe tied low, 6 requests offered continuously
    clear_logs(); gen_en = 1'b0; t0 = cyc; n = 1;
    for (int i = 0; i < 40 && n <= 6; i++) begin
      bus.req_valid = 1'b1; bus.req_tag = TAG_W'(n);
      got = (bus.req_ready === 1'b1);
      if (cyc - t0 == 5) begin
        check("t3_level_full", 32'(level), 32'd4);
        check("t3_ready_full", 32'(bus.req_ready), 32'd0);
      end
      step();
      if (got) n++;
    end
    bus.req_valid = 1'b0;
    check("t3_all_accepted", 32'(n), 32'd7);
    if (push_log.size() == 6) begin
      check("t3_push5_cyc", 32'(push_log[4] - t0), 32'd4);
      check("t3_push6_cyc", 32'(push_log[5] - t0), 32'd13);
    end else check("t3_push_n", 32'(push_log.size()), 32'd6);
    if (cmp_log.size() > 0) begin
      check("t3_cmp0_cyc", 32'(cmp_log[0].c - t0), 32'd11);
      check("t3_cmp0_to", 32'(cmp_log[0].to), 32'd1);
    end
    gen_en = 1'b1;
    repeat (50) step();
    check("t3_cmp_n", 32'(cmp_log.size()), 32'd6);

    // watchdog timeout, then a stray strobe in IDLE
    clear_logs(); gen_en = 1'b0; t0 = cyc;
    bus.req_valid = 1'b1; bus.req_tag = 4'hA; step();
    bus.req_valid = 1'b0;
    repeat (12) step();
    check("t4_cmp_n", 32'(cmp_log.size()), 32'd1);
    if (cmp_log.size() > 0) begin
      check("t4_cmp_cyc", 32'(cmp_log[0].c - t0), 32'(TIMEOUT + 4));
      check("t4_cmp_tag", 32'(cmp_log[0].tag), 32'hA);
      check("t4_cmp_to", 32'(cmp_log[0].to), 32'd1);
    end
    force_strobe = cyc + 1;
    repeat (5) step();
    check("t4_stray_start", 32'(start_log.size()), 32'd1);
    check("t4_stray_cmp", 32'(cmp_log.size()), 32'd1);
    check("t4_stray_busy", 32'(busy), 32'd0);

    // backpressure in CMPL with a second request queued
    clear_logs(); gen_en = 1'b1; gen_lat = 3; bus.cmp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_tag = 4'h7; step();
    bus.req_tag = 4'h8; step();
    bus.req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      got = (bus.cmp_valid === 1'b1);
    end
    check("t5_wait_cmp", 32'(got), 32'd1);
    repeat (5) begin
      step();
      check("t5_hold_valid", 32'(bus.cmp_valid), 32'd1);
      check("t5_hold_tag", 32'(bus.cmp_tag), 32'h7);
      check("t5_hold_to", 32'(bus.cmp_timeout), 32'd0);
    end
    check("t5_no_start", 32'(start_log.size()), 32'd1);
    bus.cmp_ready = 1'b1;
    repeat (14) step();
    check("t5_cmp_n", 32'(cmp_log.size()), 32'd2);
    if (cmp_log.size() == 2) check("t5_cmp2_tag", 32'(cmp_log[1].tag), 32'h8);

    // strobe lands on the cycle where the watchdog expires
    clear_logs(); gen_en = 1'b0; t0 = cyc;
    force_strobe = t0 + TIMEOUT + 3;
    bus.req_valid = 1'b1; bus.req_tag = 4'hC; step();
    bus.req_valid = 1'b0;
    repeat (TIMEOUT + 6) step();
    check("t6_cmp_n", 32'(cmp_log.size()), 32'd1);
    if (cmp_log.size() > 0) begin
      check("t6_cmp_cyc", 32'(cmp_log[0].c - t0), 32'(TIMEOUT + 4));
      check("t6_cmp_to", 32'(cmp_log[0].to), 32'd0);
    end

    // reset in WAIT with two requests queued
    clear_logs(); gen_en = 1'b0; t0 = cyc;
    for (int i = 1; i <= 3; i++) begin
      bus.req_valid = 1'b1; bus.req_tag = TAG_W'(i + 8); step();
    end
    bus.req_valid = 1'b0;
    step();
    check("t7_level_pre", 32'(level), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check("t7_rst_start", 32'(start), 32'd0);
    check("t7_rst_cmp_valid", 32'(bus.cmp_valid), 32'd0);
    check("t7_rst_cmp_tag", 32'(bus.cmp_tag), 32'd0);
    check("t7_rst_cmp_to", 32'(bus.cmp_timeout), 32'd0);
    check("t7_rst_level", 32'(level), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_ready", 32'(bus.req_ready), 32'd1);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
    check("t7_post_start", 32'(start_log.size()), 32'd0);
    check("t7_post_cmp", 32'(cmp_log.size()), 32'd0);
    check("t7_post_level", 32'(level), 32'd0);
    check("t7_post_ready", 32'(bus.req_ready), 32'd1);

    // randomized traffic
    clear_logs(); gen_en = 1'b1; rnd_strobe = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) gen_lat = int'($urandom_range(5));
      if (i % 300 == 0) gen_en = ($urandom_range(3) != 0);
      bus.req_valid = ($urandom_range(2) == 0);
      bus.req_tag   = TAG_W'($urandom);
      bus.cmp_ready = ($urandom_range(3) != 0);
      step();
    end
    bus.req_valid = 1'b0; bus.cmp_ready = 1'b1; rnd_strobe = 1'b0; gen_en = 1'b1;
    repeat (100) step();
    check("rnd_drain_level", 32'(level), 32'd0);
    check("rnd_drain_busy", 32'(busy), 32'd0);
    check("rnd_balance", 32'(cmp_log.size()), 32'(start_log.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
